if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 PC_write  input  1  1 = PC may advance; 0 = hold PC (load-use stall).
REQ-005 IF_IDWrite  input  1  1 = IF/ID register may load; 0 = hold IF/ID contents.
REQ-006 branch_taken  input  1  branch resolved taken in ID; redirect request.
REQ-007 branch_target  input  32  branch destination address.
REQ-008 jump  input  1  unconditional jump in ID; redirect request.
REQ-009 jump_target  input  32  jump destination address.
REQ-010 instr_in  input  32  instruction returned by instruction memory for pc_out, same cycle.
REQ-011 pc_out  output  32  current fetch address to instruction memory.
REQ-012 IF_ID_PC4  output  32  registered PC+4 of the instruction held in IF/ID.
REQ-013 IF_ID_Instr  output  32  registered instruction held in IF/ID.
REQ-014 IF_IDRs  output  5  IF_ID_Instr[25:21], combinational from the register.
REQ-015 IF_IDRt  output  5  IF_ID_Instr[20:16], combinational from the register.
REQ-016 IF_ID_valid  output  1  1 = IF/ID holds a real fetched instruction; 0 = bubble.
REQ-017 stall_cnt  output  16  count of cycles with PC_write=0 and no redirect.
REQ-018 flush_cnt  output  16  count of redirect cycles.

Function
REQ-019 Redirect = branch_taken | jump; on simultaneous assertion, branch_taken SHALL win (next PC = branch_target).
REQ-020 Next PC priority: redirect target > (PC_write=1 ? pc_out+4 : pc_out).
REQ-021 Redirect SHALL load PC even when PC_write=0.
REQ-022 Target addresses SHALL have bits [1:0] forced to 0 before loading PC.
REQ-023 PC+4 SHALL be 32-bit modular; 0xFFFFFFFC advances to 0x00000000.
REQ-024 IF/ID priority: redirect -> flush (Instr=0x00000000, PC4=0, valid=0) > IF_IDWrite=1 -> load (Instr=instr_in, PC4=pc_out+4, valid=1) > hold.
REQ-025 Flush SHALL override IF_IDWrite=0.
REQ-026 Fetch-to-IF/ID latency SHALL be exactly one cycle: instruction at pc_out in cycle N appears on IF_ID_Instr in cycle N+1.
REQ-027 With PC_write=0 and IF_IDWrite=0 (no redirect), pc_out, IF_ID_Instr, IF_ID_PC4, IF_ID_valid SHALL be unchanged next cycle.
REQ-028 stall_cnt SHALL increment by 1 per cycle with PC_write=0 and no redirect, saturating at 0xFFFF.
REQ-029 flush_cnt SHALL increment by 1 per redirect cycle, saturating at 0xFFFF.
REQ-030 Outputs other than IF_IDRs/IF_IDRt SHALL be registered; no combinational path from any input to any output.

Reset
REQ-031 While rst=1 at a rising edge: pc_out=0x00000000, IF_ID_Instr=0x00000000, IF_ID_PC4=0, IF_ID_valid=0, stall_cnt=0, flush_cnt=0.
REQ-032 rst SHALL take priority over redirect, stall and load in the same cycle.
REQ-033 Reset asserted mid-stall or mid-redirect SHALL discard the pending action; first fetch after release is address 0x00000000.

Verification
REQ-034 Reset release, PC_write=IF_IDWrite=1, instr_in=0x8C220004 -> cycle 1: pc_out=0x4, IF_ID_Instr=0x8C220004, IF_ID_PC4=0x4, IF_IDRs=1, IF_IDRt=2, valid=1.
REQ-035 At pc_out=0x10, PC_write=IF_IDWrite=0 for 2 cycles -> pc_out stays 0x10, IF/ID unchanged, stall_cnt=2; release -> pc_out=0x14.
REQ-036 At pc_out=0x20, branch_taken=1, branch_target=0x103 -> next pc_out=0x100, IF_ID_Instr=0, valid=0, flush_cnt=1.
REQ-037 branch_taken=1 (target 0x40), jump=1 (target 0x80), PC_write=0 -> pc_out=0x40, IF/ID flushed, stall_cnt unchanged.
REQ-038 pc_out=0xFFFFFFFC, PC_write=1 -> pc_out=0x00000000, IF_ID_PC4=0x00000000.
REQ-039 stall_cnt preset to 0xFFFF by 65535 stall cycles, one more stall -> stall_cnt stays 0xFFFF; rst=1 during stall -> all outputs per REQ-031.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, redirect/stall next-PC selection,
// IF/ID pipeline register with flush, and stall/flush event counters.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   PC_write          1 = PC advances by 4, 0 = PC holds (load-use stall)
//   IF_IDWrite        1 = IF/ID loads the fetched instruction, 0 = holds
//   branch_taken      redirect to branch_target (wins over jump)
//   branch_target     branch destination, bits [1:0] ignored
//   jump              redirect to jump_target
//   jump_target       jump destination, bits [1:0] ignored
//   instr_in          instruction memory read data for pc_out
//   pc_out            current fetch address
//   IF_ID_PC4         PC+4 of the instruction held in IF/ID
//   IF_ID_Instr       instruction held in IF/ID
//   IF_IDRs, IF_IDRt  rs / rt fields decoded from IF_ID_Instr
//   IF_ID_valid       1 = IF/ID holds a fetched instruction, 0 = bubble
//   stall_cnt         saturating count of stall cycles without redirect
//   flush_cnt         saturating count of redirect cycles
module if_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        PC_write,
   input  logic        IF_IDWrite,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic [31:0] instr_in,
   output logic [31:0] pc_out,
   output logic [31:0] IF_ID_PC4,
   output logic [31:0] IF_ID_Instr,
   output logic [4:0]  IF_IDRs,
   output logic [4:0]  IF_IDRt,
   output logic        IF_ID_valid,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
   } if_id_t;

   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   logic [31:0] pc_q;
   logic [31:0] pc_next;
   logic [31:0] pc_plus4;
   logic [31:0] redirect_pc;
   logic        redirect;
   logic        stall_cycle;

   if_id_t      if_id_q;
   if_id_t      if_id_next;

   logic [15:0] stall_q;
   logic [15:0] stall_next;
   logic [15:0] flush_q;
   logic [15:0] flush_next;

   // Redirect target selection; branch has priority over jump and
   // targets are word aligned by dropping the two low bits.
   always_comb begin
      redirect    = branch_taken | jump;
      redirect_pc = branch_taken ? branch_target : jump_target;
      redirect_pc = redirect_pc & 32'hFFFF_FFFC;
   end

   // Wraps modulo 2^32 by construction.
   assign pc_plus4 = pc_q + 32'd4;

   // A redirect overrides the stall: the PC must leave the wrong path
   // even while a load-use hazard is holding the front end.
   always_comb begin
      pc_next = pc_q;
      if (redirect) begin
         pc_next = redirect_pc;
      end else if (PC_write) begin
         pc_next = pc_plus4;
      end
   end

   // Flush beats IF_IDWrite=0 so the wrong-path instruction never
   // survives in IF/ID as a held value.
   always_comb begin
      if_id_next = if_id_q;
      if (redirect) begin
         if_id_next.instr = 32'h0000_0000;
         if_id_next.pc4   = 32'h0000_0000;
         if_id_next.valid = 1'b0;
      end else if (IF_IDWrite) begin
         if_id_next.instr = instr_in;
         if_id_next.pc4   = pc_plus4;
         if_id_next.valid = 1'b1;
      end
   end

   assign stall_cycle = ~PC_write & ~redirect;

   always_comb begin
      stall_next = stall_q;
      flush_next = flush_q;
      if (stall_cycle && (stall_q != CNT_MAX)) begin
         stall_next = stall_q + 16'd1;
      end
      if (redirect && (flush_q != CNT_MAX)) begin
         flush_next = flush_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= 32'h0000_0000;
         if_id_q <= '0;
         stall_q <= 16'd0;
         flush_q <= 16'd0;
      end else begin
         pc_q    <= pc_next;
         if_id_q <= if_id_next;
         stall_q <= stall_next;
         flush_q <= flush_next;
      end
   end

   assign pc_out      = pc_q;
   assign IF_ID_PC4   = if_id_q.pc4;
   assign IF_ID_Instr = if_id_q.instr;
   assign IF_ID_valid = if_id_q.valid;
   assign stall_cnt   = stall_q;
   assign flush_cnt   = flush_q;

   // Register-field decode straight off the IF/ID register.
   assign IF_IDRs = if_id_q.instr[25:21];
   assign IF_IDRt = if_id_q.instr[20:16];

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: per-feature tasks with a
// model-fed expected-state queue plus literal checks of key scenarios.
module tb_if_stage;

   logic        clk;
   logic        rst;
   logic        PC_write;
   logic        IF_IDWrite;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic [31:0] instr_in;
   logic [31:0] pc_out;
   logic [31:0] IF_ID_PC4;
   logic [31:0] IF_ID_Instr;
   logic [4:0]  IF_IDRs;
   logic [4:0]  IF_IDRt;
   logic        IF_ID_valid;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic [15:0] stall;
      logic [15:0] flush;
   } st_t;

   st_t sb_q[$];
   st_t m;

   if_stage dut (
      .clk          (clk),
      .rst          (rst),
      .PC_write     (PC_write),
      .IF_IDWrite   (IF_IDWrite),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .jump         (jump),
      .jump_target  (jump_target),
      .instr_in     (instr_in),
      .pc_out       (pc_out),
      .IF_ID_PC4    (IF_ID_PC4),
      .IF_ID_Instr  (IF_ID_Instr),
      .IF_IDRs      (IF_IDRs),
      .IF_IDRt      (IF_IDRt),
      .IF_ID_valid  (IF_ID_valid),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] imem(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
   endfunction

   function automatic st_t observe();
      return {pc_out, IF_ID_Instr, IF_ID_PC4, IF_ID_valid,
              stall_cnt, flush_cnt};
   endfunction

   function automatic st_t model_next(
      input st_t s, input logic r, input logic pcw, input logic ifw,
      input logic bt, input logic [31:0] btt, input logic j,
      input logic [31:0] jt, input logic [31:0] ins);
      st_t n;
      logic [31:0] tgt;
      logic redir;
      if (r) return '0;
      n = s;
      redir = bt | j;
      tgt = bt ? {btt[31:2], 2'b00} : {jt[31:2], 2'b00};
      if (redir) n.pc = tgt;
      else if (pcw) n.pc = s.pc + 32'd4;
      if (redir) begin
         n.instr = '0; n.pc4 = '0; n.valid = 1'b0;
      end else if (ifw) begin
         n.instr = ins; n.pc4 = s.pc + 32'd4; n.valid = 1'b1;
      end
      if (!pcw && !redir && s.stall != 16'hFFFF) n.stall = s.stall + 1;
      if (redir && s.flush != 16'hFFFF) n.flush = s.flush + 1;
      return n;
   endfunction

   // Drive one cycle of stimulus, push the expected post-edge state,
   // then advance past the edge.
   task automatic drive(
      input logic r, input logic pcw, input logic ifw,
      input logic bt, input logic [31:0] btt, input logic j,
      input logic [31:0] jt, input logic [31:0] ins);
      rst = r; PC_write = pcw; IF_IDWrite = ifw;
      branch_taken = bt; branch_target = btt;
      jump = j; jump_target = jt; instr_in = ins;
      m = model_next(m, r, pcw, ifw, bt, btt, j, jt, ins);
      sb_q.push_back(m);
      @(posedge clk);
      #1;
   endtask

   task automatic run(input logic pcw, input logic ifw);
      drive(1'b0, pcw, ifw, 1'b0, '0, 1'b0, '0, imem(pc_out));
   endtask

   task automatic test_reset();
      st_t e, o;
      drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 32'hDEAD_BEEF);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0400, 1'b1, 32'h800,
            32'h1234_5678);
      drive(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h0000_0900,
            32'h1234_5678);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
      end
      o = observe();
      checks++;
      if (o !== '0 || IF_IDRs !== 5'd0 || IF_IDRt !== 5'd0) begin
         failures++;
         $display("FAIL reset: got %h rs=%0d rt=%0d, want all zero",
                  o, IF_IDRs, IF_IDRt);
      end
   endtask

   task automatic test_first_fetch();
      st_t e, o;
      drive(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 32'h8C22_0004);
      e = sb_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL first_fetch_sb: got %h want %h", o, e);
      end
      checks++;
      if (pc_out !== 32'h4 || IF_ID_Instr !== 32'h8C22_0004 ||
          IF_ID_PC4 !== 32'h4 || IF_IDRs !== 5'd1 ||
          IF_IDRt !== 5'd2 || IF_ID_valid !== 1'b1) begin
         failures++;
         $display("FAIL first_fetch: pc=%h ins=%h pc4=%h rs=%0d rt=%0d v=%b, want 4 8c220004 4 1 2 1",
                  pc_out, IF_ID_Instr, IF_ID_PC4, IF_IDRs, IF_IDRt,
                  IF_ID_valid);
      end
   endtask

   task automatic test_stall();
      st_t e, o, held;
      repeat (3) begin
         run(1'b1, 1'b1);
         e = sb_q.pop_front();
      end
      held = observe();
      checks++;
      if (pc_out !== 32'h10) begin
         failures++;
         $display("FAIL stall_setup: pc=%h want 00000010", pc_out);
      end
      run(1'b0, 1'b0);
      e = sb_q.pop_front();
      run(1'b0, 1'b0);
      e = sb_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL stall_sb: got %h want %h", o, e);
      end
      checks++;
      if (pc_out !== 32'h10 || stall_cnt !== 16'd2 ||
          IF_ID_Instr !== held.instr || IF_ID_PC4 !== held.pc4 ||
          IF_ID_valid !== held.valid) begin
         failures++;
         $display("FAIL stall_hold: pc=%h stall=%0d ins=%h pc4=%h, want 10 2 %h %h",
                  pc_out, stall_cnt, IF_ID_Instr, IF_ID_PC4,
                  held.instr, held.pc4);
      end
      run(1'b1, 1'b1);
      e = sb_q.pop_front();
      checks++;
      if (pc_out !== 32'h14 || IF_ID_PC4 !== 32'h14) begin
         failures++;
         $display("FAIL stall_release: pc=%h pc4=%h want 14 14",
                  pc_out, IF_ID_PC4);
      end
   endtask

   task automatic test_branch();
      st_t e, o;
      repeat (3) begin
         run(1'b1, 1'b1);
         e = sb_q.pop_front();
      end
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0103, 1'b0, '0,
            imem(pc_out));
      e = sb_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL branch_sb: got %h want %h", o, e);
      end
      checks++;
      if (pc_out !== 32'h100 || IF_ID_Instr !== 32'h0 ||
          IF_ID_valid !== 1'b0 || flush_cnt !== 16'd1) begin
         failures++;
         $display("FAIL branch: pc=%h ins=%h v=%b flush=%0d, want 100 0 0 1",
                  pc_out, IF_ID_Instr, IF_ID_valid, flush_cnt);
      end
   endtask

   task automatic test_priority();
      st_t e;
      run(1'b1, 1'b1);
      e = sb_q.pop_front();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, imem(pc_out));
      e = sb_q.pop_front();
      checks++;
      if (pc_out !== 32'h40 || IF_ID_Instr !== 32'h0 ||
          IF_ID_PC4 !== 32'h0 || IF_ID_valid !== 1'b0 ||
          stall_cnt !== 16'd2 || flush_cnt !== 16'd2) begin
         failures++;
         $display("FAIL br_over_jump: pc=%h ins=%h pc4=%h v=%b stall=%0d flush=%0d, want 40 0 0 0 2 2",
                  pc_out, IF_ID_Instr, IF_ID_PC4, IF_ID_valid,
                  stall_cnt, flush_cnt);
      end
      run(1'b1, 1'b1);
      e = sb_q.pop_front();
      drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 32'h207, imem(pc_out));
      e = sb_q.pop_front();
      checks++;
      if (pc_out !== 32'h204 || IF_ID_valid !== 1'b0 ||
          IF_ID_Instr !== 32'h0 || flush_cnt !== 16'd3) begin
         failures++;
         $display("FAIL jump_flush: pc=%h v=%b ins=%h flush=%0d, want 204 0 0 3",
                  pc_out, IF_ID_valid, IF_ID_Instr, flush_cnt);
      end
   endtask

   task automatic test_wrap();
      st_t e;
      drive(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1, 32'hFFFF_FFFF,
            imem(pc_out));
      e = sb_q.pop_front();
      checks++;
      if (pc_out !== 32'hFFFF_FFFC) begin
         failures++;
         $display("FAIL wrap_setup: pc=%h want fffffffc", pc_out);
      end
      run(1'b1, 1'b1);
      e = sb_q.pop_front();
      checks++;
      if (pc_out !== 32'h0 || IF_ID_PC4 !== 32'h0 ||
          IF_ID_valid !== 1'b1) begin
         failures++;
         $display("FAIL wrap: pc=%h pc4=%h v=%b want 0 0 1",
                  pc_out, IF_ID_PC4, IF_ID_valid);
      end
   endtask

   task automatic test_back_to_back();
      st_t e, o;
      int bad;
      logic pcw, ifw, bt, j;
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         pcw = ($urandom_range(0, 3) != 0);
         ifw = ($urandom_range(0, 3) != 0);
         bt  = ($urandom_range(0, 7) == 0);
         j   = ($urandom_range(0, 7) == 0);
         drive(1'b0, pcw, ifw, bt, $urandom, j, $urandom, imem(pc_out));
         e = sb_q.pop_front();
         o = observe();
         if (o !== e) begin
            bad++;
            if (bad <= 5)
               $display("FAIL b2b cycle %0d: got %h want %h", i, o, e);
         end
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL b2b_total: got %0d bad cycles want 0", bad);
      end
   endtask

   task automatic test_stall_sat();
      st_t e, o;
      int bad;
      bad = 0;
      while (m.stall != 16'hFFFF) begin
         run(1'b0, 1'b0);
         e = sb_q.pop_front();
         o = observe();
         if (o !== e) bad++;
      end
      checks++;
      if (bad != 0 || stall_cnt !== 16'hFFFF) begin
         failures++;
         $display("FAIL sat_fill: bad=%0d stall=%h want 0 ffff",
                  bad, stall_cnt);
      end
      run(1'b0, 1'b1);
      e = sb_q.pop_front();
      checks++;
      if (stall_cnt !== 16'hFFFF || observe() !== e) begin
         failures++;
         $display("FAIL sat_hold: stall=%h want ffff", stall_cnt);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, imem(pc_out));
      e = sb_q.pop_front();
      checks++;
      if (observe() !== '0) begin
         failures++;
         $display("FAIL sat_reset: got %h want 0", observe());
      end
      run(1'b1, 1'b1);
      e = sb_q.pop_front();
      checks++;
      if (IF_ID_PC4 !== 32'h4 || pc_out !== 32'h4 ||
          IF_ID_Instr !== imem(32'h0)) begin
         failures++;
         $display("FAIL post_reset_fetch: pc=%h pc4=%h ins=%h want 4 4 %h",
                  pc_out, IF_ID_PC4, IF_ID_Instr, imem(32'h0));
      end
   endtask

   initial begin
      m = '0;
      rst = 1'b1; PC_write = 1'b0; IF_IDWrite = 1'b0;
      branch_taken = 1'b0; branch_target = '0;
      jump = 1'b0; jump_target = '0; instr_in = '0;
      test_reset();
      test_first_fetch();
      test_stall();
      test_branch();
      test_priority();
      test_wrap();
      test_back_to_back();
      test_stall_sat();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
